// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// Holds the buffered-result entry layout and the parameter defaults.
package wb_pkg;

    localparam int BUF_DEPTH_DEF    = 2;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    // x0 is hardwired to zero, so writes to it are accepted but never performed.
    function automatic logic rd_writes(input logic [4:0] rd);
        return rd != 5'd0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Result buffer for multi-cycle writebacks: push, pop, head view, and rd-match invalidate.
// Head is visible combinationally; push/pop take effect on the next edge; caller never overflows.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [4:0]    i_push_rd,
    input  logic [31:0]   i_push_data,
    input  logic          i_pop,
    input  logic          i_inv,
    input  logic [4:0]    i_inv_rd,
    output wb_entry_t     o_head,
    output logic [CW-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // A younger pipeline write supersedes every buffered result for that rd.
            if (i_inv) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_mem[i].rd == i_inv_rd) begin
                        r_mem[i].valid <= 1'b0;
                    end
                end
            end
            if (i_push) begin
                r_mem[r_tail] <= '{valid: 1'b1, rd: i_push_rd, data: i_push_data};
                r_tail        <= ptr_inc(r_tail);
            end
            if (i_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/wb_arbiter.sv
// Single-port register-file write arbiter: pipeline WB vs multi-cycle results, zero-cycle grant.
// Multi-cycle results wait in a small buffer (mc_ready on free space); pipe_hold only on forced drain.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int BUF_DEPTH    = BUF_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wb_en,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wb_data,
    output logic        pipe_hold,
    input  logic        mc_valid,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [1:0]  buf_count
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [SW-1:0] r_starve;
    wb_entry_t     w_head;
    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_head_ok;
    logic          w_forced;
    logic          w_pipe_grant;
    logic          w_head_write;
    logic          w_silent_pop;
    logic          w_pop;
    logic          w_bypass;
    logic          w_mc_discard;
    logic          w_push;
    logic          w_inv;

    wb_fifo #(
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_rd   (mc_rd),
        .i_push_data (mc_data),
        .i_pop       (w_pop),
        .i_inv       (w_inv),
        .i_inv_rd    (pipe_rd),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign w_empty   = (w_count == '0);
    assign w_head_ok = ~w_empty & w_head.valid;
    assign w_forced  = w_head_ok & (r_starve >= LIMIT_C);

    assign w_pipe_grant = pipe_wb_en & ~w_forced;
    assign w_head_write = w_forced | (w_head_ok & ~pipe_wb_en);
    // Superseded entries need no write port, so they drain alongside any grant.
    assign w_silent_pop = ~w_empty & ~w_head.valid;
    assign w_pop        = w_head_write | w_silent_pop;

    assign mc_ready     = ~rst & (w_count < DEPTH_C);
    assign w_bypass     = w_empty & ~pipe_wb_en & mc_valid;
    assign w_mc_discard = ~rd_writes(mc_rd) | (pipe_wb_en & (pipe_rd == mc_rd));
    assign w_push       = mc_valid & mc_ready & ~w_bypass & ~w_mc_discard;
    assign w_inv        = w_pipe_grant & rd_writes(pipe_rd);

    assign pipe_hold = ~rst & w_forced & pipe_wb_en;
    assign buf_count = 2'(w_count);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (w_pipe_grant) begin
            rf_we    = rd_writes(pipe_rd);
            rf_waddr = pipe_rd;
            rf_wdata = pipe_wb_data;
        end else if (w_head_write) begin
            rf_we    = w_head.valid;
            rf_waddr = w_head.rd;
            rf_wdata = w_head.data;
        end else if (w_bypass) begin
            rf_we    = rd_writes(mc_rd);
            rf_waddr = mc_rd;
            rf_wdata = mc_data;
        end
        if (rst) begin
            rf_we = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_pop || w_empty) begin
            r_starve <= '0;
        end else if (w_pipe_grant) begin
            r_starve <= r_starve + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboarded bench for wb_arbiter: each cycle's expected register write is queued, then matched.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wb_en;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wb_data;
    logic        pipe_hold;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  buf_count;

    wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wb_en   (pipe_wb_en),
        .pipe_rd      (pipe_rd),
        .pipe_wb_data (pipe_wb_data),
        .pipe_hold    (pipe_hold),
        .mc_valid     (mc_valid),
        .mc_rd        (mc_rd),
        .mc_data      (mc_data),
        .mc_ready     (mc_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .buf_count    (buf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] shadow [32];
    int          n_chk = 0;
    int          n_err = 0;
    string       cur   = "init";
    logic [1:0]  s_cnt;
    logic        s_rdy;
    logic        s_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // One clock: drive at negedge, sample comb outputs 2ns later, then let the edge commit.
    task automatic step(input logic pe, input logic [4:0] prd, input logic [31:0] pd,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        exp_t e;
        @(negedge clk);
        pipe_wb_en   = pe;
        pipe_rd      = prd;
        pipe_wb_data = pd;
        mc_valid     = mv;
        mc_rd        = mrd;
        mc_data      = md;
        #2;
        s_cnt  = buf_count;
        s_rdy  = mc_ready;
        s_hold = pipe_hold;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({cur, "/we"},    32'(rf_we), 32'd1);
            check({cur, "/waddr"}, 32'(rf_waddr), 32'(e.a));
            check({cur, "/wdata"}, rf_wdata, e.d);
        end else begin
            check({cur, "/no_we"}, 32'(rf_we), 32'd0);
        end
        if (rf_we) shadow[rf_waddr] = rf_wdata;
        @(posedge clk);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        rst = 1'b1;
        pipe_wb_en = 1'b0; pipe_rd = '0; pipe_wb_data = '0;
        mc_valid = 1'b0; mc_rd = '0; mc_data = '0;

        cur = "reset";
        repeat (2) @(posedge clk);
        @(negedge clk);
        pipe_wb_en = 1'b1; pipe_rd = 5'd2; mc_valid = 1'b1; mc_rd = 5'd5;
        #2;
        check("reset/rf_we", 32'(rf_we), 32'd0);
        check("reset/mc_ready", 32'(mc_ready), 32'd0);
        check("reset/pipe_hold", 32'(pipe_hold), 32'd0);
        check("reset/buf_count", 32'(buf_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pipe_wb_en = 1'b0; pipe_rd = '0; mc_valid = 1'b0; mc_rd = '0;
        #2;
        check("release/mc_ready", 32'(mc_ready), 32'd1);

        cur = "bypass";
        expect_wr(5'd5, 32'hAAAA_0001);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hAAAA_0001);
        check("bypass/buf_count", 32'(s_cnt), 32'd0);
        idle();
        check("bypass/buf_after", 32'(s_cnt), 32'd0);

        cur = "drain";
        expect_wr(5'd1, 32'h100);
        step(1'b1, 5'd1, 32'h100, 1'b1, 5'd6, 32'h66);
        expect_wr(5'd1, 32'h101);
        step(1'b1, 5'd1, 32'h101, 1'b1, 5'd7, 32'h77);
        check("drain/cnt_c1", 32'(s_cnt), 32'd1);
        expect_wr(5'd6, 32'h66);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88);
        check("drain/full_cnt", 32'(s_cnt), 32'd2);
        check("drain/full_rdy", 32'(s_rdy), 32'd0);
        expect_wr(5'd7, 32'h77);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88);
        check("drain/rdy_after_pop", 32'(s_rdy), 32'd1);
        check("drain/cnt_c3", 32'(s_cnt), 32'd1);
        expect_wr(5'd8, 32'h88);
        idle();
        check("drain/pushpop_cnt", 32'(s_cnt), 32'd1);
        idle();
        check("drain/empty", 32'(s_cnt), 32'd0);

        cur = "starve";
        expect_wr(5'd1, 32'h200);
        step(1'b1, 5'd1, 32'h200, 1'b1, 5'd9, 32'h99);
        for (int k = 1; k <= 4; k++) begin
            expect_wr(5'd2, 32'h200 + 32'(k));
            step(1'b1, 5'd2, 32'h200 + 32'(k), 1'b0, 5'd0, 32'd0);
            check("starve/no_hold", 32'(s_hold), 32'd0);
        end
        expect_wr(5'd9, 32'h99);
        step(1'b1, 5'd2, 32'h205, 1'b0, 5'd0, 32'd0);
        check("starve/hold", 32'(s_hold), 32'd1);
        expect_wr(5'd2, 32'h205);
        step(1'b1, 5'd2, 32'h205, 1'b0, 5'd0, 32'd0);
        check("starve/resume_hold", 32'(s_hold), 32'd0);
        check("starve/resume_cnt", 32'(s_cnt), 32'd0);
        idle();

        cur = "waw";
        expect_wr(5'd1, 32'h300);
        step(1'b1, 5'd1, 32'h300, 1'b1, 5'd3, 32'h11);
        expect_wr(5'd3, 32'h22);
        step(1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 32'd0);
        idle();
        check("waw/stale_cnt", 32'(s_cnt), 32'd1);
        idle();
        check("waw/dropped", 32'(s_cnt), 32'd0);
        check("waw/x3", shadow[3], 32'h22);

        cur = "waw_same";
        expect_wr(5'd4, 32'h44);
        step(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h55);
        check("waw_same/rdy", 32'(s_rdy), 32'd1);
        idle();
        check("waw_same/cnt", 32'(s_cnt), 32'd0);
        check("waw_same/x4", shadow[4], 32'h44);

        cur = "x0";
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        step(1'b1, 5'd0, 32'hBEEF, 1'b1, 5'd0, 32'hDEAD);
        idle();
        check("x0/cnt", 32'(s_cnt), 32'd0);

        cur = "midrst";
        expect_wr(5'd1, 32'h400);
        step(1'b1, 5'd1, 32'h400, 1'b1, 5'd10, 32'hA0);
        expect_wr(5'd1, 32'h401);
        step(1'b1, 5'd1, 32'h401, 1'b1, 5'd11, 32'hB0);
        @(negedge clk);
        pipe_wb_en = 1'b0; mc_valid = 1'b0; mc_rd = '0;
        #1;
        check("midrst/pre_cnt", 32'(buf_count), 32'd2);
        rst = 1'b1;
        pipe_wb_en = 1'b1; pipe_rd = 5'd12; pipe_wb_data = 32'hC0;
        #1;
        check("midrst/rf_we", 32'(rf_we), 32'd0);
        check("midrst/cnt", 32'(buf_count), 32'd0);
        check("midrst/rdy", 32'(mc_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pipe_wb_en = 1'b0; pipe_rd = '0; pipe_wb_data = '0;
        idle();
        check("midrst/rdy_after", 32'(s_rdy), 32'd1);
        check("midrst/cnt_after", 32'(s_cnt), 32'd0);
        idle();
        check("midrst/x10", shadow[10], 32'd0);
        check("midrst/x11", shadow[11], 32'd0);
        check("end/queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 2: depth of the multi-cycle result buffer.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: number of consecutive pipeline-won cycles before a forced drain.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port pipe_wb_en  in  1  WB stage requests a register write this cycle.
REQ-006 SHALL have port pipe_rd  in  5  WB stage destination register.
REQ-007 SHALL have port pipe_wb_data  in  32  WB stage data, the output of the writeback-select mux.
REQ-008 SHALL have port pipe_hold  out  1  WB write not accepted this cycle; WB stage re-presents the same write next cycle.
REQ-009 SHALL have port mc_valid  in  1  multi-cycle unit result valid.
REQ-010 SHALL have port mc_rd  in  5  multi-cycle result destination register.
REQ-011 SHALL have port mc_data  in  32  multi-cycle result data.
REQ-012 SHALL have port mc_ready  out  1  arbiter accepts the multi-cycle result this cycle.
REQ-013 SHALL have port rf_we  out  1  register-file write enable.
REQ-014 SHALL have port rf_waddr  out  5  register-file write address.
REQ-015 SHALL have port rf_wdata  out  32  register-file write data.
REQ-016 SHALL have port buf_count  out  2  number of buffered entries.

Function
REQ-017 SHALL drive the rf_* outputs combinationally from the current inputs and state, with zero-cycle latency for every granted write.
REQ-018 SHALL grant by priority: forced drain, then pipeline, then buffer head, then direct multi-cycle bypass.
REQ-019 SHALL bypass when buffer empty, pipe_wb_en=0 and mc_valid=1: write mc_rd/mc_data directly in the same cycle, with nothing buffered.
REQ-020 SHALL enqueue when mc_valid and mc_ready and the result is neither bypassed nor discarded; mc_ready = (buf_count < BUF_DEPTH), derived from registered count only.
REQ-021 SHALL, when the buffer is non-empty and not forced: write pipe if pipe_wb_en=1, otherwise pop the head and write it.
REQ-022 SHALL keep a starve counter that increments on each cycle the buffer is non-empty and the pipe wins, and clears on any buffer pop or when the buffer is empty.
REQ-023 SHALL enter forced drain when the counter reaches STARVE_LIMIT: pipe_hold=1 if pipe_wb_en=1, pop and write the head, clear the counter.
REQ-024 SHALL never assert rf_we for address 0; x0 results from either source are accepted, discarded and never enqueued.
REQ-025 SHALL handle WAW: a granted pipe write to rd invalidates every buffered entry with the same rd; invalid entries are popped silently without rf_we, in one cycle each.
REQ-026 SHALL handle WAW on simultaneous arrival: when mc_valid and pipe_wb_en target the same nonzero rd in the same cycle, accept the mc result (mc_ready permitting), discard it, and write the pipe value.
REQ-027 SHALL handle simultaneous enqueue and pop in one cycle, leaving buf_count unchanged and preserving FIFO order.
REQ-028 SHALL, when full with mc_valid=1: hold mc_ready=0 until a pop; mc_data must stay stable (producer rule).
REQ-029 SHALL assert pipe_hold only during forced drain.

Reset
REQ-030 SHALL clear buffer, valid bits, buf_count and starve counter while rst=1.
REQ-031 SHALL force rf_we=0, pipe_hold=0 and mc_ready=0 while rst=1; mc_ready=1 from the first cycle after release.
REQ-032 SHALL, on rst asserted mid-operation, discard buffered results without writing them; no partial write.

Structure
REQ-033 SHALL place BUF_DEPTH/STARVE_LIMIT defaults and typedef wb_entry_t {valid, rd[4:0], data[31:0]} in shared package wb_pkg.
REQ-034 SHALL implement the buffer as sub-module wb_fifo (push, pop, head, count, per-entry rd-match invalidate); arbitration and starve logic stay in wb_arbiter.

Verification
REQ-035 SHALL cover bypass: empty buffer, pipe idle, mc_valid rd=5 data=0xAAAA0001 -> same cycle rf_we=1 waddr=5 wdata=0xAAAA0001, buf_count=0.
REQ-036 SHALL cover buffer then drain: pipe writes rd=1 in cycles 0-1 while mc delivers rd=6 and rd=7 -> buf_count=2, mc_ready=0; pipe idle at cycle 2 -> rd=6 written, then rd=7.
REQ-037 SHALL cover starvation: buffer holds rd=9, pipe_wb_en=1 continuously -> 4 pipe writes, 5th cycle pipe_hold=1 with rd=9 written, 6th cycle pipe write resumes.
REQ-038 SHALL cover WAW: buffer holds rd=3 data=0x11; pipe writes rd=3 data=0x22 -> entry dropped without rf_we, final x3=0x22.
REQ-039 SHALL cover x0 and reset: mc rd=0 -> no rf_we, buf_count=0; rst pulsed with buf_count=2 -> buf_count=0, no rf_we, mc_ready=1 after release.
